// File: rtl/pcihellocore_led_pkg.sv
// pcihellocore LED bank: shared register addresses and STATUS layout.
// Used by pcihellocore_led_bank (blink engine under LED_BANK_BLINK_EN).
package pcihellocore_led_pkg;

    localparam logic [2:0] LED_ADDR_DATA   = 3'd0;
    localparam logic [2:0] LED_ADDR_SET    = 3'd1;
    localparam logic [2:0] LED_ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] LED_ADDR_MASK   = 3'd3;
    localparam logic [2:0] LED_ADDR_DIV    = 3'd4;
    localparam logic [2:0] LED_ADDR_STATUS = 3'd5;

    localparam int LED_STATUS_PHASE_BIT = 0;
    localparam int LED_STATUS_CNT_LSB   = 1;
    localparam int LED_STATUS_CNT_MAXW  = 31;

endpackage

// File: rtl/pcihellocore_led_blink_timer.sv
// Blink prescaler: DIV_W-bit down-counter with a phase flag that
// toggles every DIV+1 cycles; DIV=0 parks the phase high.
module pcihellocore_led_blink_timer
    import pcihellocore_led_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             div_wr,
    output logic             phase,
    output logic [DIV_W-1:0] cnt
);

    logic             r_phase;
    logic [DIV_W-1:0] r_cnt;
    logic             w_div_zero;
    logic             w_cnt_zero;

    assign w_div_zero = (div == '0);
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (div_wr) begin
            // a new divider restarts the period but keeps the phase
            r_cnt <= div;
            if (w_div_zero) begin
                r_phase <= 1'b1;
            end
        end else if (w_div_zero) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_cnt_zero) begin
            r_cnt   <= div;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign phase = r_phase;
    assign cnt   = r_cnt;

endmodule

// File: rtl/pcihellocore_led_bank.sv
// Avalon-MM LED bank with DATA/SET/CLEAR registers; the blink engine,
// BLINK_MASK, BLINK_DIV and STATUS exist only with LED_BANK_BLINK_EN.
module pcihellocore_led_bank
    import pcihellocore_led_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               DIV_W       = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [31:0]      w_rdata;
    logic             w_unused;
    logic [WIDTH-1:0] r_data;

    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign w_unused = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
        end else if (w_wr) begin
            case (address)
                LED_ADDR_DATA:  r_data <= w_wd;
                LED_ADDR_SET:   r_data <= r_data | w_wd;
                LED_ADDR_CLEAR: r_data <= r_data & ~w_wd;
                default:        r_data <= r_data;
            endcase
        end
    end

`ifdef LED_BANK_BLINK_EN
    localparam int CNT_W = (DIV_W > LED_STATUS_CNT_MAXW) ?
                           LED_STATUS_CNT_MAXW : DIV_W;

    logic [WIDTH-1:0] r_mask;
    logic [DIV_W-1:0] r_div;
    logic             w_div_wr;
    logic [DIV_W-1:0] w_div;
    logic             w_phase;
    logic [DIV_W-1:0] w_cnt;

    assign w_div_wr = w_wr && (address == LED_ADDR_DIV);
    assign w_div    = w_div_wr ? writedata[DIV_W-1:0] : r_div;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_div  <= '0;
        end else begin
            if (w_wr && (address == LED_ADDR_MASK)) begin
                r_mask <= w_wd;
            end
            if (w_div_wr) begin
                r_div <= w_div;
            end
        end
    end

    pcihellocore_led_blink_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (w_div),
        .div_wr  (w_div_wr),
        .phase   (w_phase),
        .cnt     (w_cnt)
    );

    assign out_port = r_data & (~r_mask | {WIDTH{w_phase}});

    always_comb begin
        w_rdata = '0;
        case (address)
            LED_ADDR_DATA: w_rdata[WIDTH-1:0] = r_data;
            LED_ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
            LED_ADDR_DIV:  w_rdata[DIV_W-1:0] = r_div;
            LED_ADDR_STATUS: begin
                w_rdata[LED_STATUS_PHASE_BIT] = w_phase;
                w_rdata[LED_STATUS_CNT_LSB +: CNT_W] = w_cnt[CNT_W-1:0];
            end
            default: w_rdata = '0;
        endcase
    end
`else
    assign out_port = r_data;

    always_comb begin
        w_rdata = '0;
        case (address)
            LED_ADDR_DATA: w_rdata[WIDTH-1:0] = r_data;
            default:       w_rdata = '0;
        endcase
    end
`endif

    assign readdata = w_rdata;

endmodule

// File: tb/tb_pcihellocore_led_bank.sv
// Self-checking bench for pcihellocore_led_bank (WIDTH=8, RESET_VALUE=A5);
// blink checks are compiled in when LED_BANK_BLINK_EN is defined.
module tb_pcihellocore_led_bank;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;
    localparam int         DW = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [W-1:0] out_port;

    int total = 0;
    int bad = 0;

    // reference model state: closed-form blink timing since last DIV write
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    int unsigned m_div;
    int unsigned m_t0;
    bit          m_p0;
    int unsigned edges = 0;

    pcihellocore_led_bank #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .DIV_W       (DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (reset_n) edges <= edges + 1;

    function automatic bit m_phase(int unsigned e);
        if (m_div == 0) return 1'b1;
        return m_p0 ^ bit'(((e - m_t0) / (m_div + 1)) & 1);
    endfunction

    function automatic int unsigned m_cnt(int unsigned e);
        if (m_div == 0) return 0;
        return m_div - ((e - m_t0) % (m_div + 1));
    endfunction

    function automatic logic [7:0] m_out();
`ifdef LED_BANK_BLINK_EN
        return m_data & (~m_mask | {8{m_phase(edges)}});
`else
        return m_data;
`endif
    endfunction

    function automatic logic [31:0] m_read(int a);
        logic [31:0] r;
        r = 32'h0;
        if (a == 0) r = {24'h0, m_data};
`ifdef LED_BANK_BLINK_EN
        if (a == 3) r = {24'h0, m_mask};
        if (a == 4) r = m_div;
        if (a == 5) r = (m_cnt(edges) << 1) | 32'(m_phase(edges));
`endif
        return r;
    endfunction

    task automatic m_reset();
        m_data = RV;
        m_mask = 8'h00;
        m_div  = 0;
        m_p0   = 1'b1;
        m_t0   = edges;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(int a, logic [31:0] wd);
        int unsigned d;
        bit p;
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'(a);
        writedata  = wd;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        case (a)
            0: m_data = wd[7:0];
            1: m_data = m_data | wd[7:0];
            2: m_data = m_data & ~wd[7:0];
`ifdef LED_BANK_BLINK_EN
            3: m_mask = wd[7:0];
            4: begin
                d = wd[DW-1:0];
                p = (d == 0) ? 1'b1 : m_phase(edges - 1);
                m_p0  = p;
                m_t0  = edges;
                m_div = d;
            end
`endif
            default: ;
        endcase
    endtask

    task automatic check_all(string tag);
        @(negedge clk);
        chk({tag, ".out"}, 32'(out_port), 32'(m_out()));
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            chk($sformatf("%s.rd%0d", tag, a), readdata, m_read(a));
        end
    endtask

    task automatic check_out_cycles(string tag, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s.c%0d", tag, i), 32'(out_port), 32'(m_out()));
            address = 3'd5;
            #1;
            chk($sformatf("%s.st%0d", tag, i), readdata, m_read(5));
        end
    endtask

    initial begin
        int a;
        logic [31:0] wd;

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_held", 32'(out_port), 32'(RV));
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        check_all("reset");
        address = 3'd5;
        #1;
`ifdef LED_BANK_BLINK_EN
        chk("reset.status", readdata, 32'h1);
`else
        chk("reset.status", readdata, 32'h0);
`endif

        wr(0, 32'h0000_000F);
        wr(1, 32'hFFFF_FFF0);
        wr(2, 32'h0000_0081);
        #1;
        chk("dsc.out", 32'(out_port), 32'h7E);
        check_all("dsc");

        for (int i = 0; i < 30; i++) begin
            a  = int'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 4) wd = $urandom_range(0, 4);
            wr(a, wd);
            check_all($sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            check_out_cycles($sformatf("rndw%0d", i), 2);
        end

`ifdef LED_BANK_BLINK_EN
        wr(0, 32'hFF);
        wr(3, 32'h01);
        wr(4, 32'h3);
        check_out_cycles("blink3", 12);
        chk("blink3.hi", 32'(out_port[7:1]), 32'h7F);
        wr(4, 32'h0);
        #1;
        chk("div0.edge", 32'(out_port), 32'hFF);
        check_out_cycles("div0", 6);
        @(negedge clk);
        chk("div0.steady", 32'(out_port), 32'hFF);
        wr(4, 32'h1);
        check_out_cycles("div1", 8);
        check_all("div1");
`else
        wr(3, 32'hFF);
        check_all("nomask");
        chk("nomask.out", 32'(out_port), 32'(m_data));
`endif

        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst.out", 32'(out_port), 32'(RV));
        m_reset();
        check_all("arst");
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        check_all("post_rst");
        check_out_cycles("post_rst", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcihellocore_led_bank.md
# pcihellocore_led_bank

Parametrised Avalon-MM LED/output-port slave, the successor to the fixed 8-bit output PIO in the pcihellocore Qsys system. It adds configurable width, atomic write-1-to-set and write-1-to-clear registers, and a per-bit hardware blink engine driven by a programmable prescaler. Host software on the PCIe side can flash LEDs without polling.

## Interface
- `WIDTH`, 8, output port width; legal range 1..32.
- `RESET_VALUE`, 0, DATA register value at reset (WIDTH bits).
- `DIV_W`, 24, prescaler width in bits; legal range 1..32.
- `clk` in 1: single system clock; every flop is in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 3: register word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, qualified by `chipselect`.
- `writedata` in 32: write data; bits above the field width are ignored.
- `readdata` out 32: read data; unused upper bits read 0.
- `out_port` out WIDTH: LED drive.

## Operation
- Register map (word addresses):
  - 0 DATA: RW.
  - 1 SET: W1S on DATA; reads 0.
  - 2 CLEAR: W1C on DATA; reads 0.
  - 3 BLINK_MASK: RW, WIDTH bits.
  - 4 BLINK_DIV: RW, DIV_W bits.
  - 5 STATUS: RO. bit0 = phase, bits[DIV_W:1] = current counter (truncated to 31 bits).
  - 6, 7: read 0, writes ignored.
- A write occurs on a cycle with `chipselect=1`, `write_n=0`. There are no wait states. At most one register changes per cycle.
- DATA update rules:
  - SET: `data <= data | wd[WIDTH-1:0]`.
  - CLEAR: `data <= data & ~wd[WIDTH-1:0]`.
- Blink engine: DIV_W-bit down-counter `cnt` and 1-bit `phase`.
  - DIV = 0: counter holds at 0, `phase` is forced to 1, no toggling.
  - DIV ≠ 0 and `cnt` = 0: `phase` toggles and `cnt` reloads DIV. Otherwise `cnt` decrements. Half-period is DIV+1 cycles.
  - Writing BLINK_DIV loads `cnt` with the new value on the same edge. `phase` is unchanged unless the new DIV is 0, in which case `phase` becomes 1.
- Output function: `out_port[i] = data[i] & (~mask[i] | phase)`. A blinking bit is on only while `phase`=1, and only if its DATA bit is 1.
- Reset values:
  - DATA = RESET_VALUE; MASK = 0; DIV = 0; `cnt` = 0; `phase` = 1.
  - `out_port` = RESET_VALUE.
  - `readdata` follows `address` combinationally.
- Reset asserted mid-operation clears all state immediately and asynchronously. No write is in flight across reset.

## Timing
- `readdata` is a combinational function of `address` and registered state, valid in the same cycle (zero read latency).
- A write becomes visible in registers and on `out_port` at the capturing clock edge. `out_port` is driven from flops, so there is no combinational path from the bus.
- A phase toggle updates `out_port` at the same edge that `phase` flips.
- The STATUS counter value read in a cycle is the pre-edge value.

## Configuration
- `LED_BANK_BLINK_EN` defined: blink engine, BLINK_MASK, BLINK_DIV and STATUS are present as specified.
- Not defined:
  - No counter, phase, mask or div flops are built.
  - Addresses 3–5 read 0 and ignore writes.
  - `out_port` = DATA.
  - DATA/SET/CLEAR behaviour is unchanged.

## Structure
- Package `pcihellocore_led_pkg` holds the address constants `LED_ADDR_DATA`..`LED_ADDR_STATUS` and the STATUS bit positions.
- Sub-module `pcihellocore_led_blink_timer` (parameter DIV_W):
  - Inputs: `div`, `div_wr`.
  - Outputs: `phase`, `cnt`.
  - Instantiated only under `LED_BANK_BLINK_EN`.
- The top level holds the register file, read mux and output function.

## Test plan
- Reset with WIDTH=8, RESET_VALUE=8'hA5 → `out_port`=8'hA5; reads: addr0 = 32'h000000A5, addr3 = 0, addr5 = 32'h1 (phase 1, cnt 0).
- Write DATA=0x0F, SET=0xF0, CLEAR=0x81 → DATA reads 0x7E; addr1 and addr2 read 0; `out_port`=0x7E one edge after the last write.
- With DATA=0xFF, MASK=0x01, DIV=3 → `out_port[0]` toggles every 4 cycles (0xFE/0xFF); bits 7:1 stay 1.
- Mid-blink, write DIV=0 → `phase`=1 at that edge, `out_port`=0xFF steady; then write DIV=1 → toggles every 2 cycles.
- Assert `reset_n` low asynchronously mid-period → `out_port`=RESET_VALUE immediately; all registers return to reset values.
- Build without `LED_BANK_BLINK_EN`, write MASK=0xFF → addr3 reads 0; `out_port` equals DATA.
